dds_dac_spi_tx: RTL and testbench

//  Downstream stage of DDS_Top. Takes the 13-bit two's-complement sample stream (dout/out_valid),

---
 rtl/dds_dac_spi_tx.sv | 151 +++++++++++++++
 tb/tb_dds_dac_spi_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_dac_spi_tx.sv
// DDS sample to SPI DAC transmitter: offset-binary conversion, CMD prefix, FIFO, MSB-first SPI shifter.
// Optional ramp test pattern on payload when DDS_DAC_TESTPAT_EN is defined (adds test_mode input).
module dds_dac_spi_tx #(
   parameter int unsigned DW         = 13,
   parameter int unsigned FRAME_BITS = 16,
   parameter logic [FRAME_BITS-DW-1:0] CMD = 3'b011,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CLK_DIV    = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          en,
   input  logic                          in_valid,
   input  logic [DW-1:0]                 in_data,
`ifdef DDS_DAC_TESTPAT_EN
   input  logic                          test_mode,
`endif
   input  logic                          ovf_clr,
   output logic                          sclk,
   output logic                          mosi,
   output logic                          cs_n,
   output logic                          busy,
   output logic                          ovf,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned LW  = AW + 1;
   localparam int unsigned CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned FCW = $clog2(FRAME_BITS);
   localparam logic [DW-1:0] SIGN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t                state, state_nxt;
   logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [FRAME_BITS-1:0] shreg, wr_frame;
   logic [CW-1:0]         cnt;
   logic [FCW-1:0]        fcnt;
   logic                  cnt_last, empty, full, push, pop, drop, flush, fall;
   logic                  sclk_nxt, cs_n_nxt, busy_nxt;

   assign empty    = (level == '0);
   assign full     = (level == LW'(FIFO_DEPTH));
   assign cnt_last = (cnt == CW'(CLK_DIV - 1));
   // A pop in the same cycle frees a slot, so a push at full is still accepted.
   assign push     = en & in_valid & (~full | pop);
   assign drop     = en & in_valid & full & ~pop;
   assign flush    = (state == IDLE) & ~en;
   assign mosi     = shreg[FRAME_BITS-1];

`ifdef DDS_DAC_TESTPAT_EN
   logic [DW-1:0] ramp;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                  ramp <= '0;
      else if (push && test_mode) ramp <= ramp + DW'(1);
   end

   assign wr_frame = {CMD, (test_mode ? ramp : (in_data ^ SIGN))};
`else
   assign wr_frame = {CMD, in_data ^ SIGN};
`endif

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_frame;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en && !empty) state_nxt = SETUP;
         SETUP:   if (cnt_last) state_nxt = SHIFT;
         SHIFT:   if (cnt_last && sclk && (fcnt == FCW'(FRAME_BITS - 1))) state_nxt = HOLD;
         HOLD:    if (cnt_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs are derived from state_nxt.
   always_comb begin
      pop      = 1'b0;
      fall     = 1'b0;
      sclk_nxt = 1'b0;
      case (state)
         IDLE:    pop = en & ~empty;
         SHIFT: begin
            sclk_nxt = cnt_last ? ~sclk : sclk;
            fall     = cnt_last & sclk;
         end
         default: ;
      endcase
      cs_n_nxt = !((state_nxt == SETUP) || (state_nxt == SHIFT));
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sclk  <= 1'b0;
         cs_n  <= 1'b1;
         busy  <= 1'b0;
         cnt   <= '0;
         fcnt  <= '0;
         shreg <= '0;
      end else begin
         sclk <= sclk_nxt;
         cs_n <= cs_n_nxt;
         busy <= busy_nxt;
         cnt  <= ((state == IDLE) || cnt_last) ? '0 : cnt + CW'(1);
         if (pop) begin
            shreg <= mem[rd_ptr];
            fcnt  <= '0;
         end else if (fall) begin
            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            fcnt  <= fcnt + FCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_dds_dac_spi_tx.sv
// Directed bench for dds_dac_spi_tx; a negedge monitor decodes SPI frames into queues.
module tb_dds_dac_spi_tx;

   logic        clk = 1'b0;
   logic        rstn, en, in_valid, ovf_clr;
   logic [12:0] in_data;
   logic        sclk, mosi, cs_n, busy, ovf;
   logic [3:0]  level;
`ifdef DDS_DAC_TESTPAT_EN
   logic        test_mode = 1'b0;
`endif

   int checks = 0;
   int passed = 0;

   logic [15:0] fq [$];
   int          lq [$];
   int          rq [$];
   int          gq [$];

   logic [15:0] mon_sh;
   int          mon_low, mon_rise, mon_high;
   logic        mon_prev_cs, mon_prev_sclk;

   dds_dac_spi_tx #(
      .DW(13), .FRAME_BITS(16), .CMD(3'b011), .FIFO_DEPTH(8), .CLK_DIV(2)
   ) dut (
      .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid), .in_data(in_data),
`ifdef DDS_DAC_TESTPAT_EN
      .test_mode(test_mode),
`endif
      .ovf_clr(ovf_clr), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy),
      .ovf(ovf), .level(level)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Frame decoder: shifts mosi in on each sclk rise seen while cs_n is low.
   always @(negedge clk) begin
      if (!rstn) begin
         mon_low = 0; mon_rise = 0; mon_high = -1;
         mon_prev_cs = 1'b1; mon_prev_sclk = 1'b0; mon_sh = '0;
      end else begin
         if (cs_n === 1'b0) begin
            if (mon_prev_cs === 1'b1) begin
               gq.push_back(mon_high);
               mon_low = 0; mon_rise = 0; mon_sh = '0;
            end
            mon_low++;
            if (sclk === 1'b1 && mon_prev_sclk === 1'b0) begin
               mon_sh = {mon_sh[14:0], mosi};
               mon_rise++;
            end
         end else if (mon_prev_cs === 1'b0) begin
            fq.push_back(mon_sh); lq.push_back(mon_low); rq.push_back(mon_rise);
            mon_high = 1;
         end else if (mon_high >= 0) begin
            mon_high++;
         end
         mon_prev_cs = cs_n; mon_prev_sclk = sclk;
      end
   end

   task clear_q();
      fq.delete(); lq.delete(); rq.delete(); gq.delete();
   endtask

   task wait_frames(input int n, input int budget, output bit ok);
      int t;
      t = 0;
      while (fq.size() < n && t < budget) begin @(negedge clk); t++; end
      ok = (fq.size() >= n);
   endtask

   task wait_cs_low(input int budget, output bit ok);
      int t;
      t = 0;
      while (cs_n !== 1'b0 && t < budget) begin @(negedge clk); t++; end
      ok = (cs_n === 1'b0);
   endtask

   task push_sample(input logic [12:0] d);
      in_valid = 1'b1; in_data = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task test_reset();
      rstn = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (sclk !== 1'b0)  $display("FAIL reset_sclk: got %b want 0", sclk);  else passed++;
      checks++; if (mosi !== 1'b0)  $display("FAIL reset_mosi: got %b want 0", mosi);  else passed++;
      checks++; if (cs_n !== 1'b1)  $display("FAIL reset_cs_n: got %b want 1", cs_n);  else passed++;
      checks++; if (busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", busy);  else passed++;
      checks++; if (ovf !== 1'b0)   $display("FAIL reset_ovf: got %b want 0", ovf);    else passed++;
      checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else passed++;
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (cs_n !== 1'b1)  $display("FAIL idle_cs_n: got %b want 1", cs_n);   else passed++;
   endtask

   task test_single();
      bit ok;
      clear_q();
      in_valid = 1'b1; in_data = 13'h0000;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (cs_n !== 1'b1)  $display("FAIL lat_n1_cs_n: got %b want 1", cs_n);  else passed++;
      checks++; if (level !== 4'd1) $display("FAIL lat_n1_level: got %0d want 1", level); else passed++;
      @(negedge clk);
      checks++; if (cs_n !== 1'b0)  $display("FAIL lat_n2_cs_n: got %b want 0", cs_n);  else passed++;
      checks++; if (busy !== 1'b1)  $display("FAIL lat_n2_busy: got %b want 1", busy);  else passed++;
      checks++; if (level !== 4'd0) $display("FAIL lat_n2_level: got %0d want 0", level); else passed++;
      wait_frames(1, 200, ok);
      checks++; if (!ok) $display("FAIL single_timeout: got %0d frames want 1", fq.size()); else passed++;
      if (ok) begin
         checks++; if (fq[0] !== 16'h7000) $display("FAIL single_data: got %h want 7000", fq[0]); else passed++;
         checks++; if (lq[0] != 66) $display("FAIL single_cs_low: got %0d want 66", lq[0]); else passed++;
         checks++; if (rq[0] != 16) $display("FAIL single_rises: got %0d want 16", rq[0]); else passed++;
      end
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL single_end_busy: got %b want 0", busy); else passed++;
      checks++; if (sclk !== 1'b0) $display("FAIL single_end_sclk: got %b want 0", sclk); else passed++;
      checks++; if (mosi !== 1'b0) $display("FAIL single_end_mosi: got %b want 0", mosi); else passed++;
   endtask

   task test_back_to_back();
      bit ok;
      clear_q();
      in_valid = 1'b1; in_data = 13'h1FFF;
      @(negedge clk);
      in_data = 13'h0FFF;
      @(negedge clk);
      in_valid = 1'b0;
      wait_frames(2, 300, ok);
      checks++; if (!ok) $display("FAIL b2b_timeout: got %0d frames want 2", fq.size()); else passed++;
      if (ok) begin
         checks++; if (fq[0] !== 16'h6FFF) $display("FAIL b2b_frame0: got %h want 6fff", fq[0]); else passed++;
         checks++; if (fq[1] !== 16'h7FFF) $display("FAIL b2b_frame1: got %h want 7fff", fq[1]); else passed++;
         checks++; if (gq[1] != 3) $display("FAIL b2b_gap: got %0d want 3", gq[1]); else passed++;
      end
      repeat (5) @(negedge clk);
   endtask

   task test_overflow();
      bit ok;
      clear_q();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = 13'(i); ovf_clr = (i == 9);
         @(negedge clk);
         if (i == 8) begin
            checks++; if (level !== 4'd8) $display("FAIL ovf_level9: got %0d want 8", level); else passed++;
            checks++; if (ovf !== 1'b0)   $display("FAIL ovf_early: got %b want 0", ovf);     else passed++;
         end
      end
      in_valid = 1'b0; ovf_clr = 1'b0;
      checks++; if (ovf !== 1'b1)   $display("FAIL ovf_set_wins: got %b want 1", ovf);     else passed++;
      checks++; if (level !== 4'd8) $display("FAIL ovf_level10: got %0d want 8", level); else passed++;
      wait_frames(9, 9 * 69 + 100, ok);
      checks++; if (!ok) $display("FAIL ovf_timeout: got %0d frames want 9", fq.size()); else passed++;
      if (ok) begin
         for (int k = 0; k < 9; k++) begin
            checks++;
            if (fq[k] !== 16'h7000 + 16'(k)) $display("FAIL ovf_frame%0d: got %h want %h", k, fq[k], 16'h7000 + 16'(k));
            else passed++;
         end
      end
      repeat (150) @(negedge clk);
      checks++; if (fq.size() != 9) $display("FAIL ovf_frame_count: got %0d want 9", fq.size()); else passed++;
      checks++; if (level !== 4'd0) $display("FAIL ovf_drained: got %0d want 0", level); else passed++;
      checks++; if (ovf !== 1'b1)   $display("FAIL ovf_sticky: got %b want 1", ovf);     else passed++;
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++; if (ovf !== 1'b0)   $display("FAIL ovf_clr: got %b want 0", ovf);        else passed++;
   endtask

   task test_en_drop();
      bit ok;
      clear_q();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 13'h0100 + 13'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_frames(1, 200, ok);
      if (ok) wait_cs_low(20, ok);
      checks++; if (!ok) $display("FAIL en_frame2_start: got cs_n %b want 0", cs_n); else passed++;
      repeat (20) @(negedge clk);
      en = 1'b0;
      push_sample(13'h0000);
      checks++; if (level !== 4'd3) $display("FAIL en_ignore_push: got %0d want 3", level); else passed++;
      wait_frames(2, 200, ok);
      checks++; if (!ok) $display("FAIL en_timeout: got %0d frames want 2", fq.size()); else passed++;
      if (ok) begin
         checks++; if (fq[1] !== 16'h7101) $display("FAIL en_frame2: got %h want 7101", fq[1]); else passed++;
      end
      repeat (10) @(negedge clk);
      checks++; if (level !== 4'd0) $display("FAIL en_flush: got %0d want 0", level); else passed++;
      checks++; if (busy !== 1'b0)  $display("FAIL en_busy: got %b want 0", busy);   else passed++;
      checks++; if (ovf !== 1'b0)   $display("FAIL en_ovf: got %b want 0", ovf);     else passed++;
      repeat (100) @(negedge clk);
      checks++; if (fq.size() != 2) $display("FAIL en_frame_count: got %0d want 2", fq.size()); else passed++;
      checks++; if (cs_n !== 1'b1)  $display("FAIL en_cs_idle: got %b want 1", cs_n); else passed++;
      en = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (cs_n !== 1'b1)  $display("FAIL en_reenable_cs: got %b want 1", cs_n); else passed++;
      checks++; if (level !== 4'd0) $display("FAIL en_reenable_level: got %0d want 0", level); else passed++;
   endtask

   task test_reset_mid();
      bit ok;
      clear_q();
      for (int i = 0; i < 3; i++) push_sample(13'(i));
      wait_cs_low(20, ok);
      checks++; if (!ok) $display("FAIL rst_frame_start: got cs_n %b want 0", cs_n); else passed++;
      repeat (30) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checks++; if (cs_n !== 1'b1)  $display("FAIL rst_async_cs_n: got %b want 1", cs_n);   else passed++;
      checks++; if (sclk !== 1'b0)  $display("FAIL rst_async_sclk: got %b want 0", sclk);   else passed++;
      checks++; if (level !== 4'd0) $display("FAIL rst_async_level: got %0d want 0", level); else passed++;
      checks++; if (busy !== 1'b0)  $display("FAIL rst_async_busy: got %b want 0", busy);   else passed++;
      checks++; if (mosi !== 1'b0)  $display("FAIL rst_async_mosi: got %b want 0", mosi);   else passed++;
      repeat (2) @(negedge clk);
      checks++; if (cs_n !== 1'b1)  $display("FAIL rst_hold_cs_n: got %b want 1", cs_n);    else passed++;
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (fq.size() != 0) $display("FAIL rst_abort: got %0d frames want 0", fq.size()); else passed++;
      push_sample(13'h0ABC);
      wait_frames(1, 200, ok);
      checks++; if (!ok) $display("FAIL rst_after_timeout: got %0d frames want 1", fq.size()); else passed++;
      if (ok) begin
         checks++; if (fq[0] !== 16'h7ABC) $display("FAIL rst_after_data: got %h want 7abc", fq[0]); else passed++;
      end
      repeat (5) @(negedge clk);
   endtask

`ifdef DDS_DAC_TESTPAT_EN
   task test_testpat();
      bit ok;
      rstn = 1'b0; test_mode = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      clear_q();
      in_valid = 1'b1; in_data = 13'h1234;
      @(negedge clk);
      in_data = 13'h0F0F;
      @(negedge clk);
      in_data = 13'h1FFF;
      @(negedge clk);
      in_valid = 1'b0;
      wait_frames(3, 300, ok);
      checks++; if (!ok) $display("FAIL tp_timeout: got %0d frames want 3", fq.size()); else passed++;
      if (ok) begin
         checks++; if (fq[0] !== 16'h6000) $display("FAIL tp_frame0: got %h want 6000", fq[0]); else passed++;
         checks++; if (fq[1] !== 16'h6001) $display("FAIL tp_frame1: got %h want 6001", fq[1]); else passed++;
         checks++; if (fq[2] !== 16'h6002) $display("FAIL tp_frame2: got %h want 6002", fq[2]); else passed++;
      end
      test_mode = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_en_drop();
      test_reset_mid();
`ifdef DDS_DAC_TESTPAT_EN
      test_testpat();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
